// File: rtl/gray_to_bin_monitor.sv
// Receive-side checker for Gray-coded counters: decodes each accepted codeword to binary and
// flags any step that is not exactly a single-bit change from the previous codeword.
module gray_to_bin_monitor #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_step_ok,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    typedef enum logic {StUnlocked, StLocked} state_e;

    localparam logic [ERR_W-1:0] ErrMax = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             ok_q, ok_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [WIDTH-1:0] dec_bin;
    logic [WIDTH-1:0] diff;
    logic [7:0]       ones;
    logic             step_ok;
    logic             accept;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        dec_bin = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            dec_bin[i] = ^(in_gray >> i);
        end
    end

    always_comb begin
        diff = prev_q ^ in_gray;
        ones = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones = ones + 8'(diff[i]);
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // A repeated codeword gives ones == 0 and is therefore illegal.
    assign step_ok  = (state_q == StUnlocked) || (ones == 8'd1);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        bin_d   = bin_q;
        valid_d = valid_q;
        ok_d    = ok_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            bin_d   = dec_bin;
            ok_d    = step_ok;
            prev_d  = in_gray;
            state_d = StLocked;
            if (!step_ok && (err_q != ErrMax)) begin
                err_d = err_q + 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StUnlocked;
            prev_q  <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_bin     = bin_q;
    assign out_step_ok = ok_q;
    assign err_count   = err_q;
    assign locked      = (state_q == StLocked);

endmodule

// File: tb/tb_gray_to_bin_monitor.sv
// Scoreboard bench: two instances (8-bit and 2-bit error counters) share one stimulus stream.
module tb_gray_to_bin_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_gray = '0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_step_ok, locked;
    logic [3:0] out_bin;
    logic [7:0] err_count;
    logic       in_ready2, out_valid2, out_step_ok2, locked2;
    logic [3:0] out_bin2;
    logic [1:0] err_count2;

    gray_to_bin_monitor #(.WIDTH(4), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .out_step_ok(out_step_ok), .err_count(err_count), .locked(locked)
    );

    gray_to_bin_monitor #(.WIDTH(4), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_gray(in_gray),
        .out_valid(out_valid2), .out_ready(out_ready), .out_bin(out_bin2),
        .out_step_ok(out_step_ok2), .err_count(err_count2), .locked(locked2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bin;
        int ok;
        int err;
        int err2;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] m_prev = '0;
    bit         m_locked = 0;
    int         m_err = 0;
    int         m_err2 = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: search for the binary value whose Gray code is g.
    function automatic int gray2bin(input logic [3:0] g);
        for (int b = 0; b < 16; b++) begin
            if (4'(b ^ (b >> 1)) == g) return b;
        end
        return -1;
    endfunction

    // Model: runs on the same edge the DUT would accept.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            m_prev   = '0;
            m_locked = 0;
            m_err    = 0;
            m_err2   = 0;
        end else if (in_valid && sb.size() == 0) begin
            exp_t e;
            e.ok = (!m_locked || $countones(m_prev ^ in_gray) == 1) ? 1 : 0;
            if (e.ok == 0) begin
                m_err  = (m_err < 255) ? m_err + 1 : 255;
                m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
            end
            e.bin    = gray2bin(in_gray);
            e.err    = m_err;
            e.err2   = m_err2;
            m_prev   = in_gray;
            m_locked = 1;
            sb.push_back(e);
        end
    end

    // Monitor: compares the head of the scoreboard, pops when the consumer takes it.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", int'(in_ready), (sb.size() == 0 || out_ready) ? 1 : 0);
            chk("out_valid", int'(out_valid), (sb.size() != 0) ? 1 : 0);
            chk("in_ready2", int'(in_ready2), (sb.size() == 0 || out_ready) ? 1 : 0);
            chk("out_valid2", int'(out_valid2), (sb.size() != 0) ? 1 : 0);
            if (sb.size() != 0 && out_valid) begin
                chk("out_bin", int'(out_bin), sb[0].bin);
                chk("out_step_ok", int'(out_step_ok), sb[0].ok);
                chk("err_count", int'(err_count), sb[0].err);
                chk("locked", int'(locked), 1);
                chk("out_bin2", int'(out_bin2), sb[0].bin);
                chk("out_step_ok2", int'(out_step_ok2), sb[0].ok);
                chk("err_count_sat", int'(err_count2), sb[0].err2);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] g, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_gray   = g;
        out_ready = r;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_bin"}, int'(out_bin), 0);
        chk({tag, "_ok"}, int'(out_step_ok), 0);
        chk({tag, "_err"}, int'(err_count), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_ready"}, int'(in_ready), 1);
        chk({tag, "_err2"}, int'(err_count2), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset_state("rst");
    endtask

    initial begin
        logic [3:0] g;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("por");

        // Basic decode
        drive(1, 4'b0000, 1);
        drive(1, 4'b0001, 1);
        drive(1, 4'b0011, 1);
        drive(1, 4'b0010, 1);
        drive(0, 4'b0000, 1);

        // Full sequence 0..15 then wrap back to 0
        pulse_reset();
        for (int b = 0; b < 16; b++) drive(1, 4'(b ^ (b >> 1)), 1);
        drive(1, 4'b0000, 1);
        drive(0, 4'b0000, 1);

        // Illegal steps: two-bit step, repeat, then a legal step
        pulse_reset();
        drive(1, 4'b0001, 1);
        drive(1, 4'b0010, 1);
        drive(1, 4'b0010, 1);
        drive(1, 4'b0110, 1);
        drive(0, 4'b0000, 1);

        // Backpressure, then drain and accept on the same edge
        pulse_reset();
        drive(1, 4'b0000, 0);
        drive(1, 4'b0001, 0);
        drive(1, 4'b0001, 0);
        drive(1, 4'b0001, 1);
        drive(0, 4'b0000, 1);

        // Saturation of the narrow counter
        pulse_reset();
        drive(1, 4'b0000, 1);
        repeat (5) drive(1, 4'b0000, 1);
        drive(0, 4'b0000, 1);

        // Reset while a result is pending and a codeword is offered
        drive(1, 4'b0001, 0);
        drive(1, 4'b0011, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset_state("mid");
        drive(1, 4'b0101, 1);
        drive(0, 4'b0000, 1);
        @(negedge clk);
        chk("post_rst_bin", int'(out_bin), 6);
        chk("post_rst_ok", int'(out_step_ok), 1);

        // Randomised traffic, biased towards legal single-bit steps
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    g = m_prev ^ (4'b0001 << $urandom_range(0, 3));
                2:       g = 4'($urandom_range(0, 15));
                default: g = m_prev;
            endcase
            drive(($urandom_range(0, 3) != 0), g, ($urandom_range(0, 3) != 0));
        end

        repeat (3) drive(0, 4'b0000, 1);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_to_bin_monitor.md
# gray_to_bin_monitor

Downstream consumer of the 4-bit binary-to-Gray converter's output. Accepts Gray codewords over a valid/ready handshake, registers the decoded binary value, and checks that each codeword differs from the previous one in exactly one bit. Non-adjacent steps increment a saturating error counter. The block is the receive-side check for Gray-coded counters and pointers in the design.

## Interface

**Parameters**
- `WIDTH`, 4: codeword width in bits.
- `ERR_W`, 8: error counter width.

**Ports**
- `clk` input, 1: single clock. All logic is on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `in_valid` input, 1: `in_gray` holds a codeword.
- `in_ready` output, 1: the block can accept a codeword this cycle.
- `in_gray` input, WIDTH: Gray codeword. Bit WIDTH-1 is the MSB.
- `out_valid` output, 1: the output register holds a result.
- `out_ready` input, 1: the consumer takes the result this cycle.
- `out_bin` output, WIDTH: decoded binary value.
- `out_step_ok` output, 1: the result is a legal single-bit step, or is the first sample after lock-up.
- `err_count` output, ERR_W: count of illegal steps, saturating.
- `locked` output, 1: a previous codeword is held for comparison.

## Operation

**Decode**
- out_bin[WIDTH-1] = g[WIDTH-1].
- out_bin[i] = out_bin[i+1] XOR g[i], for i from WIDTH-2 down to 0.
- Decode is purely combinational ahead of the output register.

**Handshake**
- in_ready = !out_valid || out_ready. This is combinational and has no dependence on in_valid.
- A codeword is accepted on a cycle where in_valid && in_ready.

**State machine (2 states)**
- UNLOCKED is the reset state; locked=0.
  - On accept: out_step_ok=1, the codeword is stored in `prev`, the state goes to LOCKED.
- LOCKED; locked=1.
  - On accept: d = prev XOR in_gray.
  - out_step_ok = 1 if popcount(d) == 1, otherwise 0.
  - d == 0 is a repeated codeword and is illegal.
  - `prev` is updated to in_gray even when the step is illegal, so the check re-synchronises.
- There is no path from LOCKED back to UNLOCKED except `rst`.

**Error counter**
- Increments by 1 on each accept with out_step_ok=0.
- Holds at 2^ERR_W−1 once saturated and never wraps.

**Output register**
- On accept, out_valid, out_bin and out_step_ok are loaded.
- If out_valid && !out_ready, all outputs hold and in_ready=0.
- If out_valid && out_ready && !accept, out_valid clears next cycle. out_bin and out_step_ok keep their last values.

## Timing

- **Reset values:** out_valid=0, out_bin=0, out_step_ok=0, err_count=0, locked=0, prev=0, state=UNLOCKED.
  - in_ready=1 in the cycle after rst deasserts.
- **Latency:** a codeword accepted at edge N appears with out_valid=1 after edge N.
  - err_count and locked update on the same edge as the output register.
- **Throughput:** one codeword per cycle while out_ready=1.
- **Simultaneous drain and accept** (out_valid && out_ready && in_valid): the new result replaces the old one on the same edge, with no bubble.
- **Wrap-around:** Gray 100…0 → 000…0 (binary 2^WIDTH−1 → 0) is a single-bit step and is legal.
- **Reset mid-operation:** rst overrides any handshake in the same cycle.
  - A pending output is discarded.
  - The next accepted codeword is treated as the first sample and gets step_ok=1.
- **Illegal step on the saturation edge:** err_count stays at its maximum value, and out_step_ok=0 is still reported.

## Test plan

1. **Basic decode.** Reset, then feed Gray 0000, 0001, 0011, 0010 back-to-back with out_ready=1.
   - Required: out_bin 0, 1, 2, 3, each on the cycle after its accept.
   - Required: out_step_ok=1 for every result, err_count=0, locked=1 after the first result.
2. **Full sequence with wrap.** Feed all 16 Gray codes in binary order 0..15, then 0 again.
   - Required: out_bin tracks 0..15 then 0, every out_step_ok=1, err_count=0.
3. **Illegal steps.** Feed 0001, 0010, 0010.
   - The two-bit step 0001 → 0010 gives out_step_ok=0 and err_count=1.
   - The repeat 0010 → 0010 gives out_step_ok=0 and err_count=2.
   - A following 0110 gives out_step_ok=1 and err_count stays at 2.
4. **Backpressure.** Hold out_ready=0 with in_valid=1.
   - Required: after one accept, in_ready=0 and out_bin holds.
   - Raise out_ready with a new codeword waiting. Required: the old result drains and the new one is accepted on the same edge; out_valid stays 1 and no result is dropped or duplicated.
5. **Saturation.** Set ERR_W=2 and drive 5 illegal steps.
   - Required: err_count sequence is 1, 2, 3, 3, 3.
6. **Reset mid-stream.** Assert rst for one cycle while out_valid=1 and in_valid=1.
   - Required: all outputs return to their reset values and locked=0.
   - Then feed 0101. Required: out_step_ok=1 and out_bin=6.
